// File: rtl/seg_page_sched.sv
// Page scheduler and serial shift sequencer for a shared 8-digit 74HC595 7-segment display.
// Define SEG_LEAD_ZERO_BLANK_EN to blank leading-zero digits (digit 7 always shown).
module seg_page_sched #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned DEB_CYC    = 20000,
    parameter int unsigned ROT_FRAMES = 0,
    parameter int unsigned DIV        = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    key_n,
    input  logic [NREQ-1:0]         req_vld,
    input  logic [32*NREQ-1:0]      req_data,
    output logic [NREQ-1:0]         req_ack,
    output logic                    ds,
    output logic                    shclk,
    output logic                    stclk,
    output logic [$clog2(NREQ)-1:0] page
);

    localparam int unsigned PageW = $clog2(NREQ);
    localparam int unsigned DebW  = $clog2(DEB_CYC + 1);
    localparam int unsigned RotW  = (ROT_FRAMES > 0) ? $clog2(ROT_FRAMES + 1) : 1;
    localparam int unsigned DivW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PageW-1:0] LastPage = PageW'(NREQ - 1);
    localparam logic [DebW-1:0]  DebMax   = DebW'(DEB_CYC);
    localparam logic [DebW-1:0]  DebLast  = DebW'(DEB_CYC - 1);
    localparam logic [DebW-1:0]  DebOne   = DebW'(1);
    localparam logic [DivW-1:0]  DivLast  = DivW'(DIV - 1);
    localparam logic [DivW-1:0]  DivOne   = DivW'(1);
    localparam logic [RotW-1:0]  RotLast  = RotW'((ROT_FRAMES > 0) ? ROT_FRAMES - 1 : 0);
    localparam logic [RotW-1:0]  RotOne   = RotW'(1);
    localparam logic [PageW-1:0] PageOne  = PageW'(1);

    typedef enum logic [1:0] {
        StLoad,
        StShift,
        StLatch
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        digit_q, digit_d;
    logic [3:0]        bit_q, bit_d;
    logic              phase_q, phase_d;
    logic [DivW-1:0]   div_q, div_d;
    logic [15:0]       word_q, word_d;
    logic [31:0]       snapshot_q, snapshot_d;
    logic [PageW-1:0]  page_q, page_d;
    logic [RotW-1:0]   rot_q, rot_d;
    logic [DebW-1:0]   deb_q, deb_d;
    logic              key_meta_q, key_sync_q;
    logic              ds_q, ds_d;
    logic              shclk_q, shclk_d;
    logic              stclk_q, stclk_d;

    logic              press;
    logic              rot_adv;
    logic              frame_end;
    logic              frame_start;
    logic              take;
    logic              cur_vld;
    logic [31:0]       cur_data;
    logic [31:0]       snap_src;
    logic [4:0]        shamt;
    logic [3:0]        nibble;
    logic              blank;
    logic [7:0]        seg;
    logic [7:0]        sel;
    logic [31:0]       chan_data [NREQ];

    function automatic logic [7:0] seg_lut(input logic [3:0] n);
        logic [7:0] s;
        unique case (n)
            4'h0: s = 8'h03;
            4'h1: s = 8'h9F;
            4'h2: s = 8'h25;
            4'h3: s = 8'h0D;
            4'h4: s = 8'h99;
            4'h5: s = 8'h49;
            4'h6: s = 8'h41;
            4'h7: s = 8'h1F;
            4'h8: s = 8'h01;
            4'h9: s = 8'h09;
            4'hA: s = 8'h11;
            4'hB: s = 8'hC1;
            4'hC: s = 8'h63;
            4'hD: s = 8'h85;
            4'hE: s = 8'h61;
            4'hF: s = 8'h71;
        endcase
        return s;
    endfunction

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_chan
        assign chan_data[gi] = req_data[32*gi +: 32];
    end

    // Debounce: count while held low, saturate at DEB_CYC so a held key fires once.
    always_comb begin
        deb_d = deb_q;
        press = 1'b0;
        if (key_sync_q) begin
            deb_d = '0;
        end else if (deb_q != DebMax) begin
            deb_d = deb_q + DebOne;
            press = (deb_q == DebLast);
        end
    end

    // Snapshot source: fresh channel data on a handshaking frame start, else the held copy.
    always_comb begin
        cur_vld     = req_vld[page_q];
        cur_data    = chan_data[page_q];
        frame_start = (state_q == StLoad) && (digit_q == 3'd0);
        take        = frame_start && cur_vld;
        snap_src    = take ? cur_data : snapshot_q;
        snapshot_d  = snap_src;
    end

    always_comb begin
        shamt  = 5'd28 - {digit_q, 2'b00};
        nibble = snap_src[shamt +: 4];
`ifdef SEG_LEAD_ZERO_BLANK_EN
        blank  = (digit_q != 3'd7) && ((snap_src >> shamt) == 32'd0);
`else
        blank  = 1'b0;
`endif
        seg    = blank ? 8'hFF : seg_lut(nibble);
        sel    = 8'h80 >> digit_q;
    end

    always_comb begin
        state_d   = state_q;
        digit_d   = digit_q;
        bit_d     = bit_q;
        phase_d   = phase_q;
        div_d     = div_q;
        word_d    = word_q;
        frame_end = 1'b0;
        unique case (state_q)
            StLoad: begin
                word_d  = {sel, seg};
                bit_d   = 4'd15;
                phase_d = 1'b0;
                div_d   = '0;
                state_d = StShift;
            end
            StShift: begin
                if (div_q == DivLast) begin
                    div_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else if (bit_q == 4'd0) begin
                        phase_d = 1'b0;
                        state_d = StLatch;
                    end else begin
                        phase_d = 1'b0;
                        bit_d   = bit_q - 4'd1;
                    end
                end else begin
                    div_d = div_q + DivOne;
                end
            end
            StLatch: begin
                if (div_q == DivLast) begin
                    div_d     = '0;
                    digit_d   = digit_q + 3'd1;
                    state_d   = StLoad;
                    frame_end = (digit_q == 3'd7);
                end else begin
                    div_d = div_q + DivOne;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    // Outputs are registered from the next state so they line up with the FSM without glitches.
    always_comb begin
        shclk_d = (state_d == StShift) && phase_d;
        stclk_d = (state_d == StLatch);
        ds_d    = ds_q;
        if ((state_d == StShift) && !phase_d) begin
            ds_d = word_d[bit_d];
        end
    end

    // A press wins over a coincident rotate and restarts the rotate interval.
    always_comb begin
        rot_d   = rot_q;
        rot_adv = 1'b0;
        if (press) begin
            rot_d = '0;
        end else if ((ROT_FRAMES > 0) && frame_end) begin
            if (rot_q == RotLast) begin
                rot_d   = '0;
                rot_adv = 1'b1;
            end else begin
                rot_d = rot_q + RotOne;
            end
        end
        page_d = page_q;
        if (press || rot_adv) begin
            page_d = (page_q == LastPage) ? '0 : page_q + PageOne;
        end
    end

    always_comb begin
        req_ack = '0;
        if (rst_n && take) begin
            req_ack[page_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_meta_q <= 1'b1;
            key_sync_q <= 1'b1;
            deb_q      <= '0;
            rot_q      <= '0;
            page_q     <= '0;
            snapshot_q <= '0;
            state_q    <= StLoad;
            digit_q    <= 3'd0;
            bit_q      <= 4'd0;
            phase_q    <= 1'b0;
            div_q      <= '0;
            word_q     <= '0;
            ds_q       <= 1'b0;
            shclk_q    <= 1'b0;
            stclk_q    <= 1'b0;
        end else begin
            key_meta_q <= key_n;
            key_sync_q <= key_meta_q;
            deb_q      <= deb_d;
            rot_q      <= rot_d;
            page_q     <= page_d;
            snapshot_q <= snapshot_d;
            state_q    <= state_d;
            digit_q    <= digit_d;
            bit_q      <= bit_d;
            phase_q    <= phase_d;
            div_q      <= div_d;
            word_q     <= word_d;
            ds_q       <= ds_d;
            shclk_q    <= shclk_d;
            stclk_q    <= stclk_d;
        end
    end

    assign ds    = ds_q;
    assign shclk = shclk_q;
    assign stclk = stclk_q;
    assign page  = page_q;

endmodule

// File: doc/seg_page_sched.md
Name: seg_page_sched

Overview:
- Scheduler and shift sequencer that shares one 8-digit serial 7-segment display (two cascaded 74HC595, 16 bits per digit) between NREQ measurement channels.
- Each channel is one 32-bit value shown as 8 hex digits, for example frequency, duty, t0 or t1.
- The block picks the displayed page from a debounced key or an auto-rotate timer, snapshots the selected channel with a valid/ack handshake, and drives ds/shclk/stclk.

Parameters:
- NREQ, 4, number of requester pages (2..8).
- DEB_CYC, 20000, cycles key_n must be stably low to count as one press.
- ROT_FRAMES, 0, frames per auto-advance; 0 disables auto-rotate.
- DIV, 4, half-period of shclk in clk cycles (>=1).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- key_n  in  1  asynchronous page key, active low.
- req_vld  in  NREQ  channel i has fresh data.
- req_data  in  32*NREQ  channel i value in bits [32i+31:32i].
- req_ack  out  NREQ  one-cycle pulse when channel i data is captured.
- ds  out  1  serial data to the shift register.
- shclk  out  1  shift clock.
- stclk  out  1  storage/latch clock.
- page  out  $clog2(NREQ)  current page, for LEDs.

Behaviour:
- Reset values (rst_n=0 at a posedge): ds=0, shclk=0, stclk=0, req_ack=0, page=0, snapshot=0, FSM=LOAD with digit=0, all counters 0.
- Reset asserted mid-frame aborts the frame immediately; the first frame after release starts at digit 0.
- Key input:
  - 2-FF synchronizer on key_n.
  - The debounce counter counts while the synchronized key is low and clears while it is high.
  - The press event fires exactly once, in the cycle the counter reaches DEB_CYC. No repeat while the key is held.
- Page advance:
  - On a press event, page <= (page==NREQ-1) ? 0 : page+1, and the rotate counter clears.
  - When ROT_FRAMES>0, the rotate counter increments at each frame end. On reaching ROT_FRAMES it clears and page advances the same way.
  - A press and a rotate in the same cycle advance page by 1 only.
- Snapshot handshake:
  - In the LOAD cycle of digit 0 (frame start), if req_vld[page]=1: snapshot <= that channel's data and req_ack[page]=1 for that cycle only.
  - Otherwise the snapshot is held and no ack is issued.
  - The page value used is the registered page at that cycle. A page change mid-frame takes effect at the next frame start.
- Digit word:
  - Digit d (0..7) shows nibble snapshot[31-4d:28-4d].
  - Word = {sel, seg}: sel = 8'h80>>d, seg from the table below. Sent MSB first.
  - seg table, active low, index 0..F: 03 9F 25 0D 99 49 41 1F 01 09 11 C1 63 85 61 71.
- FSM per digit:
  - LOAD (1 cycle): form the word, bit=15, shclk=0.
  - SHIFT: for each bit, ds=word[bit] and shclk=0 for DIV cycles, then shclk=1 for DIV cycles. ds is stable across the shclk rising edge. After bit 0's high phase, go to LATCH.
  - LATCH: shclk=0 and stclk=1 for DIV cycles. Then digit <= digit+1 mod 8 and go to LOAD.
  - The frame ends on the LATCH exit of digit 7.
- Timing: digit period = 1+33*DIV cycles (133 at DIV=4); frame = 8 digit periods (1064 at DIV=4).
- stclk and shclk are never high together. ds changes only while shclk=0.

Optional Feature:
- Macro: SEG_LEAD_ZERO_BLANK_EN.
- Defined: a digit whose nibble and all more-significant nibbles are 0 sends seg=8'hFF (all off). Digit 7 is never blanked, so value 0 shows a single "0".
- Undefined: all 8 digits are always shown, including leading zeros.

Test Plan:
- Reset then idle, DIV=4, req_vld[0]=1, data0=32'h1234ABCD:
  - req_ack[0] pulses in cycle 1 after reset release.
  - The first 16 shclk rises carry 16'h809F.
  - stclk then goes high for 4 cycles.
  - Digit 1 word 16'h4025 starts 133 cycles after the digit-0 LOAD.
- Hold key_n low 3*DEB_CYC cycles -> page increments exactly once. Three more clean presses give page 2, 3, then wrap to 0. A 100-cycle glitch low gives no change.
- ROT_FRAMES=2, no key -> page advances every 2128 cycles (DIV=4). A press mid-interval advances page and restarts the 2-frame count.
- req_vld[page]=0 at frame start with snapshot 32'hDEADBEEF held -> no ack; display words unchanged. Raise vld with 32'h0 -> next frame digit 0 word = 16'h8003.
- Assert rst_n=0 during SHIFT of digit 3 -> the next posedge gives ds/shclk/stclk=0 and page=0. After release the frame restarts at digit 0 with sel 8'h80.
- SEG_LEAD_ZERO_BLANK_EN defined, data 32'h0000_0A05:
  - digits 0-4 seg=FF;
  - digits 5, 6, 7 seg = 11, 03, 49.
  - With data 0, only digit 7 shows 03.
